// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI mode-0 byte slave.
package spi_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_st_t;

  localparam int MIN_CLK_RATIO = 8;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for pins asynchronous to clk.
// Resets to 0; a low cs held across reset then reads as no edge, so an interrupted frame is not re-entered.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_slave_byte.sv
// SPI mode-0 slave: oversampled pins, MOSI deserialised onto valid/ready, MISO fed from a one-entry holding register.
// Latency: 3 clk from an scl/cs pin edge to the registered response; rx side stalls by dropping bytes (sticky overrun).
module spi_slave_byte
  import spi_slave_pkg::*;
#(
  parameter int         CLK_FREC = 100000000,
  parameter int         SCL_FREC = 1000000,
  parameter logic [7:0] TX_IDLE  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       scl,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       rx_overrun,
  output logic       tx_underrun
);

  if (CLK_FREC / SCL_FREC < MIN_CLK_RATIO) begin : g_ratio_check
    $error("spi_slave_byte: CLK_FREC / SCL_FREC must be at least %0d", MIN_CLK_RATIO);
  end

  logic cs_s, scl_s, mosi_s;

  sync_2ff u_sync_cs   (.clk(clk), .rst(rst), .d_i(cs),   .q_o(cs_s));
  sync_2ff u_sync_scl  (.clk(clk), .rst(rst), .d_i(scl),  .q_o(scl_s));
  sync_2ff u_sync_mosi (.clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s));

  spi_st_t    state_q;
  logic       cs_prev_q, scl_prev_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_sh_q;
  logic [6:0] tx_sh_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       miso_q;
  logic       byte_done_q;
  logic       rx_ovr_q;
  logic       tx_udr_q;

  logic       cs_fall, cs_rise, scl_rise, scl_fall;
  logic       tx_wr, reload;
  logic [7:0] reload_d;
  logic [7:0] rx_byte_d;

  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;

  assign tx_ready  = ~hold_full_q & ~rst;
  assign tx_wr     = tx_valid & tx_ready;
  assign reload_d  = hold_full_q ? hold_q : TX_IDLE;
  assign rx_byte_d = {rx_sh_q, mosi_s};

  // The shift register reloads at frame start and on the fall closing each byte.
  assign reload = ((state_q == IDLE) && cs_fall) ||
                  ((state_q == ACTIVE) && !cs_rise && scl_fall && byte_done_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cs_prev_q   <= 1'b0;
      scl_prev_q  <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 7'd0;
      tx_sh_q     <= 7'd0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      byte_done_q <= 1'b0;
      rx_ovr_q    <= 1'b0;
      tx_udr_q    <= 1'b0;
    end else begin
      cs_prev_q  <= cs_s;
      scl_prev_q <= scl_s;

      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      // A write in the reload cycle lands after the old byte has moved out.
      if (reload && hold_full_q) hold_full_q <= 1'b0;
      if (tx_wr) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            state_q     <= ACTIVE;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            rx_ovr_q    <= 1'b0;
            tx_udr_q    <= ~hold_full_q;
            tx_sh_q     <= reload_d[6:0];
            miso_q      <= reload_d[7];
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_q     <= IDLE;
            miso_q      <= 1'b0;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
          end else begin
            if (scl_rise) begin
              rx_sh_q     <= rx_byte_d[6:0];
              bit_cnt_q   <= bit_cnt_q + 3'd1;
              byte_done_q <= (bit_cnt_q == 3'd7);
              if (bit_cnt_q == 3'd7) begin
                if (rx_valid_q && !rx_ready) begin
                  rx_ovr_q <= 1'b1;
                end else begin
                  rx_data_q  <= rx_byte_d;
                  rx_valid_q <= 1'b1;
                end
              end
            end
            if (scl_fall) begin
              byte_done_q <= 1'b0;
              if (byte_done_q) begin
                tx_sh_q <= reload_d[6:0];
                miso_q  <= reload_d[7];
                if (!hold_full_q) tx_udr_q <= 1'b1;
              end else begin
                tx_sh_q <= {tx_sh_q[5:0], 1'b0};
                miso_q  <= tx_sh_q[6];
              end
            end
          end
        end
      endcase
    end
  end

  assign miso        = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q == ACTIVE);
  assign rx_overrun  = rx_ovr_q;
  assign tx_underrun = tx_udr_q;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Directed bench: a mode-0 master model drives the pins at 1 MHz against a 100 MHz core clock.
module tb_spi_slave_byte;

  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b1;
  logic       scl = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       busy;
  logic       rx_overrun;
  logic       tx_underrun;

  int         n_tests = 0;
  int         n_fail = 0;
  logic       refill_en = 1'b0;
  logic [7:0] tx_next = 8'h00;
  logic [7:0] r;

  spi_slave_byte #(.CLK_FREC(100000000), .SCL_FREC(1000000), .TX_IDLE(8'hFF)) dut (
    .clk(clk), .rst(rst), .cs(cs), .scl(scl), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .rx_overrun(rx_overrun), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance on falling edges; when refill is enabled, offer tx_next whenever the holding register is empty.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (tx_valid) tx_next++;
      tx_valid = refill_en && tx_ready;
      tx_data  = tx_next;
    end
  endtask

  task automatic preload(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Shifts nbits MSB-first; returns with scl still high after the last rise.
  task automatic xfer(input logic [7:0] o, input int nbits, output logic [7:0] rcv);
    rcv = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = o[i];
      tick(HALF);
      rcv[i] = miso;
      scl = 1'b1;
      tick(HALF);
      if (i != 8 - nbits) scl = 1'b0;
    end
  endtask

  task automatic frame_begin();
    cs = 1'b0;
    tick(HALF);
  endtask

  task automatic frame_end();
    scl = 1'b0;
    tick(HALF);
    cs = 1'b1;
    tick(HALF);
  endtask

  task automatic accept_rx();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  // Each frame also pulls one byte into the shift register on its closing fall, lost at cs rise.
  logic [7:0] exp_tx [14] = '{8'd0, 8'd1, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9, 8'd10,
                              8'd12, 8'd13, 8'd14, 8'd15, 8'd16};

  initial begin
    int k;

    tick(4);
    check("tx_ready_in_reset", tx_ready, 0);
    rst = 1'b0;
    tick(2);
    check("rst_miso", miso, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rx_overrun", rx_overrun, 0);
    check("rst_tx_underrun", tx_underrun, 0);

    // Preloaded A5 out, 3C in; cs-fall latency is exactly three edges.
    preload(8'hA5);
    check("t1_tx_ready_full", tx_ready, 0);
    cs = 1'b0;
    tick(2);
    check("t1_busy_after2", busy, 0);
    tick(1);
    check("t1_busy_after3", busy, 1);
    check("t1_miso_msb", miso, 1);
    tick(HALF - 3);
    xfer(8'h3C, 8, r);
    check("t1_rx_valid", rx_valid, 1);
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_master_rx", r, 8'hA5);
    check("t1_underrun", tx_underrun, 0);
    frame_end();
    accept_rx();
    check("t1_rx_valid_accepted", rx_valid, 0);

    // Empty holding register: idle pattern both bytes.
    rx_ready = 1'b1;
    frame_begin();
    xfer(8'h11, 8, r);
    check("t2_master_rx0", r, 8'hFF);
    check("t2_underrun", tx_underrun, 1);
    scl = 1'b0;
    xfer(8'h22, 8, r);
    check("t2_master_rx1", r, 8'hFF);
    check("t2_rx_data", rx_data, 8'h22);
    frame_end();
    rx_ready = 1'b0;
    tick(1);
    check("t2_rx_valid", rx_valid, 0);

    // Overrun: second byte dropped while the first is unaccepted.
    frame_begin();
    xfer(8'h01, 8, r);
    scl = 1'b0;
    xfer(8'h02, 8, r);
    check("t3_rx_data", rx_data, 8'h01);
    check("t3_rx_valid", rx_valid, 1);
    check("t3_overrun", rx_overrun, 1);
    frame_end();
    accept_rx();
    check("t3_overrun_sticky", rx_overrun, 1);

    // Next cs fall clears overrun; cs rises after 5 bits.
    cs = 1'b0;
    tick(3);
    check("t4_overrun_cleared", rx_overrun, 0);
    check("t4_busy", busy, 1);
    tick(HALF - 3);
    xfer(8'hFF, 5, r);
    scl = 1'b0;
    tick(HALF);
    cs = 1'b1;
    tick(3);
    check("t4_busy_dropped", busy, 0);
    check("t4_miso_low", miso, 0);
    check("t4_no_rx_valid", rx_valid, 0);
    tick(HALF);
    frame_begin();
    xfer(8'h5A, 8, r);
    check("t4_rx_data", rx_data, 8'h5A);
    check("t4_rx_valid", rx_valid, 1);
    frame_end();
    accept_rx();

    // Back-to-back frames of 2..5 bytes with continuous refill.
    rx_ready  = 1'b1;
    refill_en = 1'b1;
    tx_next   = 8'h00;
    tick(4);
    k = 0;
    for (int f = 0; f < 4; f++) begin
      frame_begin();
      for (int b = 0; b < f + 2; b++) begin
        if (b != 0) scl = 1'b0;
        xfer(8'(8'h40 + k), 8, r);
        check($sformatf("t5_rx_data%0d", k), rx_data, 8'(8'h40 + k));
        check($sformatf("t5_master_rx%0d", k), r, exp_tx[k]);
        k++;
      end
      frame_end();
    end
    check("t5_overrun", rx_overrun, 0);
    check("t5_underrun", tx_underrun, 0);
    refill_en = 1'b0;
    rx_ready  = 1'b0;
    tick(2);

    // Reset pulsed during bit 4, then a clean C3 frame.
    frame_begin();
    xfer(8'hF0, 3, r);
    scl  = 1'b0;
    mosi = 1'b1;
    tick(10);
    check("t6_busy_before_rst", busy, 1);
    check("t6_rx_data_before_rst", rx_data, 8'h4D);
    rst = 1'b1;
    tick(1);
    check("t6_rst_miso", miso, 0);
    check("t6_rst_rx_data", rx_data, 8'h00);
    check("t6_rst_rx_valid", rx_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_tx_ready", tx_ready, 0);
    rst = 1'b0;
    tick(1);
    check("t6_holding_cleared", tx_ready, 1);
    tick(HALF);
    scl = 1'b1;
    tick(HALF);
    scl = 1'b0;
    tick(HALF);
    check("t6_frame_abandoned", busy, 0);
    cs = 1'b1;
    tick(HALF);
    preload(8'hC3);
    frame_begin();
    xfer(8'hC3, 8, r);
    check("t6_master_rx", r, 8'hC3);
    check("t6_rx_data", rx_data, 8'hC3);
    check("t6_rx_valid", rx_valid, 1);
    check("t6_underrun", tx_underrun, 0);
    frame_end();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_byte.md
# spi_slave_byte

SPI mode-0 slave endpoint that sits directly downstream of `apb_2_spi`, on the far end of its `cs`/`scl`/`mosi`/`miso` link. It oversamples the SPI pins with the local system clock and deserialises `mosi` into bytes on a valid/ready output. It serialises bytes from a one-entry transmit holding register onto `miso`. It is the synthesisable replacement for the behavioural SPI slave agent, and connects to a local register file or FIFO.

## Interface
- `CLK_FREC`, 100000000: local clock frequency in Hz.
- `SCL_FREC`, 1000000: maximum SPI clock in Hz. Elaboration fails unless `CLK_FREC / SCL_FREC >= 8`.
- `TX_IDLE`, 8'hFF: byte shifted out when no transmit byte is held.
- `clk` in 1: system clock. One clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cs` in 1: chip select, active low, asynchronous to `clk`.
- `scl` in 1: SPI clock, idle low, asynchronous to `clk`.
- `mosi` in 1: serial data in, MSB first.
- `miso` out 1: serial data out, MSB first. Driven 0 while `cs` is high (no tristate).
- `rx_data` out 8: last received byte.
- `rx_valid` out 1: `rx_data` is valid. Held until accepted.
- `rx_ready` in 1: consumer accepts `rx_data`.
- `tx_data` in 8: next byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: the holding register is empty.
- `busy` out 1: a frame is active (synchronised `cs` is low).
- `rx_overrun` out 1: sticky. A byte was dropped.
- `tx_underrun` out 1: sticky. `TX_IDLE` was sent.

## Operation
- **Input synchronisation:** `cs`, `scl` and `mosi` each pass through a 2-flop synchroniser. `scl` rising and falling edges, and `cs` falling and rising edges, are detected from the synchronised value and its previous-cycle copy.
- **State machine:** two states, `IDLE` and `ACTIVE`.
  - `IDLE` → `ACTIVE` on synchronised `cs` fall.
  - `ACTIVE` → `IDLE` on synchronised `cs` rise, from any bit position.
- **Frame start (`cs` fall, in the same cycle):**
  - `bit_cnt` is set to 0.
  - `rx_overrun` and `tx_underrun` are cleared.
  - The TX shift register loads the holding register if it is full, otherwise `TX_IDLE`, and `tx_underrun` is set.
  - `miso` presents bit 7.
- **Receive:**
  - On each synchronised `scl` rise in `ACTIVE`, the synchronised `mosi` value is shifted into the RX shift register, LSB in, and `bit_cnt` increments modulo 8.
  - On the 8th rise (`bit_cnt` = 7), the completed byte goes to `rx_data` and `rx_valid` is set.
  - If `rx_valid` is already high and `rx_ready` is low in that cycle, the new byte is dropped, `rx_data` is unchanged, and `rx_overrun` is set.
  - If `rx_valid && rx_ready` coincides with completion of a new byte, the new byte is loaded and `rx_valid` stays high.
- **Transmit:**
  - On each synchronised `scl` fall in `ACTIVE`, the TX shift register shifts left and `miso` presents the next bit.
  - On the fall that follows the 8th rise, the shift register instead reloads, using the same rule as at frame start.
- **Holding register:**
  - It is written when `tx_valid && tx_ready`. `tx_ready` is equal to "holding register empty".
  - A reload and a new write in the same cycle are both honoured: the old byte moves to the shift register and the new byte is stored.
- **`cs` rise mid-byte:**
  - The partial RX byte is discarded and no `rx_valid` is raised.
  - The TX shift register is discarded. The holding register content is kept for the next frame.
  - `miso` goes to 0.

## Timing
- **Reset values:** `miso` 0, `rx_data` 8'h00, `rx_valid` 0, `tx_ready` 1 after reset is released (0 during reset), `busy` 0, `rx_overrun` 0, `tx_underrun` 0, state `IDLE`, `bit_cnt` 0.
- **Pin-to-output latency**, counted in `clk` edges after the pin transition:
  - `scl` 8th rise → `rx_valid` high: 3 (2 synchroniser + 1 register).
  - `scl` fall → `miso` update: 3.
  - `cs` fall → `busy` high and MSB on `miso`: 3.
- **Margin:** an SCL half period of at least 4 `clk` keeps the `miso` update ahead of the master's next sampling rise. `mosi` is stable at the rise because the master changes it on the fall.
- **Handshakes:** standard valid/ready. A transfer occurs on a `clk` edge with both valid and ready high. `rx_valid` must not drop without acceptance.
- **`rst` mid-frame:** all state returns to reset values immediately. The frame is abandoned until the next `cs` fall.

## Structure
- Package `spi_slave_pkg`: the state enum `spi_st_t` (`IDLE`, `ACTIVE`) and the `MIN_CLK_RATIO = 8` constant.
- Sub-module `sync_2ff`: a 1-bit, 2-flop synchroniser with `clk` and `rst`. Instantiate it three times (`cs`, `scl`, `mosi`).
- The core holds the FSM, RX/TX shift registers, holding register and flags, in roughly 200 lines.

## Test plan
- Preload `tx_data` 8'hA5. The master sends 8'h3C at 1 MHz → `rx_data` 8'h3C with `rx_valid`; the master receives 8'hA5; `tx_underrun` stays 0.
- No TX byte is loaded; a 2-byte frame is sent → the master receives 8'hFF, 8'hFF; `tx_underrun` is 1 after the first byte.
- `rx_ready` is held 0; the master sends 8'h01, 8'h02 → `rx_data` stays 8'h01 and `rx_overrun` is 1; the next `cs` fall clears `rx_overrun`.
- `cs` rises after 5 bits → no `rx_valid`; `busy` is 0 within 3 clk; the next full frame with 8'h5A yields `rx_data` 8'h5A.
- Back-to-back frames of 2, 3, 4 and 5 bytes with `tx_data` 0,1,2,… refilled on `tx_ready` and `rx_ready` tied 1 → all bytes match in both directions, with no flags set.
- `rst` is pulsed during bit 4 → all outputs take their reset values on the next edge, and the following frame transfers 8'hC3 correctly.
